// File: rtl/action_scheduler.sv
// rtl/action_scheduler.sv - arbitrates user events, gravity DOWN and lock-delay LOCK into one command at a time
module action_scheduler #(
   parameter int unsigned GRAVITY_BASE = 100_000_000,
   parameter int unsigned GRAVITY_MIN  = 5_000_000,
   parameter int unsigned LOCK_TICKS   = 50_000_000,
   parameter int unsigned LOCK_RESETS  = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ctrl_valid,
   input  logic [3:0] ctrl_event,
   output logic       ctrl_pop,
   output logic       cmd_valid,
   output logic [3:0] cmd,
   output logic       cmd_src,
   input  logic       cmd_ready,
   input  logic       cmd_done,
   input  logic       cmd_ok,
   input  logic [3:0] level,
   input  logic       pause,
   input  logic       game_over,
   output logic       landed,
   output logic       busy
);

   localparam logic [3:0] EV_NONE       = 4'd0;
   localparam logic [3:0] EV_LEFT       = 4'd1;
   localparam logic [3:0] EV_RIGHT      = 4'd2;
   localparam logic [3:0] EV_DOWN       = 4'd3;
   localparam logic [3:0] EV_DROP       = 4'd4;
   localparam logic [3:0] EV_HOLD       = 4'd5;
   localparam logic [3:0] EV_ROTATE     = 4'd6;
   localparam logic [3:0] EV_ROTATE_REV = 4'd7;
   localparam logic [3:0] EV_BAR        = 4'd8;
   localparam logic [3:0] CMD_LOCK      = 4'd9;

   localparam logic [31:0] GRAV_BASE_W = GRAVITY_BASE;
   localparam logic [31:0] GRAV_MIN_W  = GRAVITY_MIN;
   localparam logic [31:0] LOCK_LAST_W = LOCK_TICKS - 1;
   localparam logic [7:0]  LOCK_RES_W  = 8'(LOCK_RESETS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] grav_cnt;
   logic [31:0] lock_cnt;
   logic [31:0] grav_shift;
   logic [31:0] grav_period;
   logic [31:0] grav_last;
   logic        grav_pend;
   logic        lock_pend;
   logic        hold_used;
   logic        last_user;
   logic        landed_r;
   logic [7:0]  reset_cnt;
   logic [3:0]  cmd_r;
   logic        src_r;

   logic        frozen;
   logic        user_discard;
   logic        pick_lock;
   logic        pick_grav;
   logic        pick_user;
   logic        done_now;
   logic        is_shift_move;

   assign frozen    = pause | game_over;
   assign cmd_valid = (state == ST_ISSUE);
   assign busy      = (state != ST_IDLE);
   assign cmd       = cmd_r;
   assign cmd_src   = src_r;
   assign landed    = landed_r;
   assign done_now  = (state == ST_WAIT) && cmd_done;

   // Codes above BAR would alias LOCK on the command bus, so they are dropped like NOEVENT.
   assign user_discard = (ctrl_event == EV_NONE) || (ctrl_event > EV_BAR) ||
                         ((ctrl_event == EV_HOLD) && hold_used);

   assign is_shift_move = (cmd_r == EV_LEFT) || (cmd_r == EV_RIGHT) ||
                          (cmd_r == EV_ROTATE) || (cmd_r == EV_ROTATE_REV);

   always_comb begin
      grav_shift  = GRAV_BASE_W >> level;
      grav_period = (grav_shift < GRAV_MIN_W) ? GRAV_MIN_W : grav_shift;
      grav_last   = grav_period - 32'd1;
   end

   always_comb begin
      state_nxt = state;
      ctrl_pop  = 1'b0;
      pick_lock = 1'b0;
      pick_grav = 1'b0;
      pick_user = 1'b0;
      case (state)
         ST_IDLE: begin
            if (reset_n && !frozen) begin
               if (lock_pend) begin
                  pick_lock = 1'b1;
                  state_nxt = ST_ISSUE;
               end else if (grav_pend && (!ctrl_valid || last_user)) begin
                  pick_grav = 1'b1;
                  state_nxt = ST_ISSUE;
               end else if (ctrl_valid) begin
                  ctrl_pop = 1'b1;
                  if (!user_discard) begin
                     pick_user = 1'b1;
                     state_nxt = ST_ISSUE;
                  end
               end
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cmd_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         grav_cnt  <= 32'd0;
         lock_cnt  <= 32'd0;
         grav_pend <= 1'b0;
         lock_pend <= 1'b0;
         hold_used <= 1'b0;
         last_user <= 1'b0;
         landed_r  <= 1'b0;
         reset_cnt <= 8'd0;
         cmd_r     <= 4'd0;
         src_r     <= 1'b0;
      end else begin
         state <= state_nxt;

         if (pick_lock) begin
            cmd_r     <= CMD_LOCK;
            src_r     <= 1'b1;
            lock_pend <= 1'b0;
         end
         if (pick_grav) begin
            cmd_r     <= EV_DOWN;
            src_r     <= 1'b1;
            grav_pend <= 1'b0;
            last_user <= 1'b0;
         end
         if (pick_user) begin
            cmd_r     <= ctrl_event;
            src_r     <= 1'b0;
            last_user <= 1'b1;
         end

         // Timers sit after the issue clears so a wrap on the issue cycle is kept.
         if (!frozen) begin
            if (grav_cnt >= grav_last) begin
               grav_cnt  <= 32'd0;
               grav_pend <= 1'b1;
            end else begin
               grav_cnt <= grav_cnt + 32'd1;
            end
            if (landed_r && !lock_pend) begin
               if (lock_cnt >= LOCK_LAST_W) begin
                  lock_pend <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt + 32'd1;
               end
            end
         end

         if (done_now) begin
            if ((cmd_r == CMD_LOCK) || (cmd_r == EV_DROP)) begin
               landed_r  <= 1'b0;
               lock_pend <= 1'b0;
               lock_cnt  <= 32'd0;
               reset_cnt <= 8'd0;
               hold_used <= 1'b0;
               grav_cnt  <= 32'd0;
               grav_pend <= 1'b0;
            end else if (src_r) begin
               if (!cmd_ok && !landed_r) begin
                  landed_r <= 1'b1;
                  lock_cnt <= 32'd0;
               end
            end else if (cmd_ok) begin
               if (is_shift_move) begin
                  if (landed_r && (reset_cnt < LOCK_RES_W)) begin
                     lock_cnt  <= 32'd0;
                     reset_cnt <= reset_cnt + 8'd1;
                  end
               end else if (cmd_r == EV_DOWN) begin
                  grav_cnt  <= 32'd0;
                  grav_pend <= 1'b0;
               end else if (cmd_r == EV_HOLD) begin
                  hold_used <= 1'b1;
                  landed_r  <= 1'b0;
                  reset_cnt <= 8'd0;
                  lock_pend <= 1'b0;
               end
            end
         end

         if (game_over) begin
            grav_pend <= 1'b0;
            lock_pend <= 1'b0;
            landed_r  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_action_scheduler.sv
// tb/tb_action_scheduler.sv - directed bench for action_scheduler with an event-queue and engine model
module tb_action_scheduler;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ctrl_valid = 1'b0;
   logic [3:0] ctrl_event = 4'd0;
   logic       ctrl_pop;
   logic       cmd_valid;
   logic [3:0] cmd;
   logic       cmd_src;
   logic       cmd_ready = 1'b0;
   logic       cmd_done = 1'b0;
   logic       cmd_ok = 1'b0;
   logic [3:0] level = 4'd0;
   logic       pause = 1'b0;
   logic       game_over = 1'b0;
   logic       landed;
   logic       busy;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int t_issue = 0;
   logic pop_q = 1'b0;
   logic [3:0] evq[$];

   always #5 clk = ~clk;

   action_scheduler #(
      .GRAVITY_BASE(100),
      .GRAVITY_MIN (5),
      .LOCK_TICKS  (20),
      .LOCK_RESETS (15)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ctrl_valid(ctrl_valid),
      .ctrl_event(ctrl_event),
      .ctrl_pop  (ctrl_pop),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .cmd_src   (cmd_src),
      .cmd_ready (cmd_ready),
      .cmd_done  (cmd_done),
      .cmd_ok    (cmd_ok),
      .level     (level),
      .pause     (pause),
      .game_over (game_over),
      .landed    (landed),
      .busy      (busy)
   );

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      pop_q <= ctrl_pop;
      if (ctrl_pop) pop_cnt <= pop_cnt + 1;
   end

   // Event queue: head presented 1 time unit after each falling edge.
   always begin
      @(negedge clk);
      #1;
      if (pop_q && evq.size() != 0) void'(evq.pop_front());
      ctrl_valid = (evq.size() != 0);
      ctrl_event = (evq.size() != 0) ? evq[0] : 4'd0;
   end

   task automatic push(input logic [3:0] ev);
      evq.push_back(ev);
   endtask

   task automatic serve(input logic ok, input int hold, output logic [3:0] c, output logic s);
      bit seen = 0;
      c = 4'd0;
      s = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (cmd_valid) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      if (seen) begin
         c = cmd;
         s = cmd_src;
         t_issue = cyc;
         cmd_ready = 1'b1;
         @(negedge clk);
         cmd_ready = 1'b0;
         repeat (hold) @(negedge clk);
         cmd_done = 1'b1;
         cmd_ok = ok;
         @(negedge clk);
         cmd_done = 1'b0;
         cmd_ok = 1'b0;
      end
   endtask

   task automatic resync();
      logic [3:0] c;
      logic s;
      push(4'd4);
      s = 1'b1;
      for (int i = 0; i < 4 && s; i++) serve(1'b1, 0, c, s);
      tests_run++;
      if (c !== 4'd4 || s !== 1'b0) begin
         tests_failed++;
         $display("FAIL resync_drop cmd=%0d src=%0d expected cmd=4 src=0", c, s);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({cmd_valid, busy, landed, ctrl_pop} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags valid/busy/landed/pop=%b expected 0000", {cmd_valid, busy, landed, ctrl_pop});
      end
      tests_run++;
      if ({cmd, cmd_src} !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_cmd cmd=%0d src=%0d expected 0 0", cmd, cmd_src);
      end
   endtask

   task automatic test_gravity();
      logic [3:0] c;
      logic s;
      int t0, t1;
      reset_n = 1'b1;
      t0 = cyc;
      serve(1'b1, 0, c, s);
      tests_run++;
      if (c !== 4'd3 || s !== 1'b1) begin
         tests_failed++;
         $display("FAIL grav_first cmd=%0d src=%0d expected cmd=3 src=1", c, s);
      end
      tests_run++;
      if (t_issue - t0 !== 101) begin
         tests_failed++;
         $display("FAIL grav_latency got=%0d expected=101", t_issue - t0);
      end
      t1 = t_issue;
      serve(1'b1, 0, c, s);
      tests_run++;
      if (c !== 4'd3 || s !== 1'b1) begin
         tests_failed++;
         $display("FAIL grav_second cmd=%0d src=%0d expected cmd=3 src=1", c, s);
      end
      tests_run++;
      if (t_issue - t1 !== 100) begin
         tests_failed++;
         $display("FAIL grav_period got=%0d expected=100", t_issue - t1);
      end
      tests_run++;
      if (pop_cnt !== 0) begin
         tests_failed++;
         $display("FAIL grav_no_pop pops=%0d expected=0", pop_cnt);
      end
   endtask

   task automatic test_alternate();
      logic [3:0] c;
      logic s;
      int p0;
      p0 = pop_cnt;
      level = 4'd4;
      repeat (3) push(4'd1);
      for (int k = 0; k < 6; k++) begin
         serve(1'b1, 6, c, s);
         tests_run++;
         if (c !== ((k % 2 == 0) ? 4'd1 : 4'd3) || s !== ((k % 2 == 0) ? 1'b0 : 1'b1)) begin
            tests_failed++;
            $display("FAIL alt_order[%0d] cmd=%0d src=%0d expected cmd=%0d src=%0d",
                     k, c, s, (k % 2 == 0) ? 1 : 3, (k % 2 == 0) ? 0 : 1);
         end
      end
      level = 4'd0;
      tests_run++;
      if (pop_cnt - p0 !== 3) begin
         tests_failed++;
         $display("FAIL alt_pops got=%0d expected=3", pop_cnt - p0);
      end
   endtask

   task automatic test_lock();
      logic [3:0] c;
      logic s;
      int tl;
      resync();
      serve(1'b0, 0, c, s);
      tests_run++;
      if (c !== 4'd3 || s !== 1'b1 || landed !== 1'b1) begin
         tests_failed++;
         $display("FAIL lock_land cmd=%0d src=%0d landed=%0d expected 3 1 1", c, s, landed);
      end
      tl = cyc;
      serve(1'b1, 0, c, s);
      tests_run++;
      if (c !== 4'd9 || s !== 1'b1) begin
         tests_failed++;
         $display("FAIL lock_cmd cmd=%0d src=%0d expected cmd=9 src=1", c, s);
      end
      tests_run++;
      if (t_issue - tl < 20 || t_issue - tl > 22) begin
         tests_failed++;
         $display("FAIL lock_delay got=%0d expected 20..22", t_issue - tl);
      end
      tests_run++;
      if (landed !== 1'b0) begin
         tests_failed++;
         $display("FAIL lock_unland landed=%0d expected=0", landed);
      end
   endtask

   task automatic test_lock_resets();
      logic [3:0] c;
      logic s;
      int t15 = 0;
      resync();
      serve(1'b0, 0, c, s);
      tests_run++;
      if (c !== 4'd3 || landed !== 1'b1) begin
         tests_failed++;
         $display("FAIL lres_land cmd=%0d landed=%0d expected 3 1", c, landed);
      end
      for (int k = 0; k < 16; k++) begin
         push(4'd6);
         serve(1'b1, 0, c, s);
         tests_run++;
         if (c !== 4'd6 || s !== 1'b0) begin
            tests_failed++;
            $display("FAIL lres_rotate[%0d] cmd=%0d src=%0d expected cmd=6 src=0", k, c, s);
         end
         if (k == 14) t15 = cyc;
      end
      serve(1'b1, 0, c, s);
      tests_run++;
      if (c !== 4'd9 || s !== 1'b1) begin
         tests_failed++;
         $display("FAIL lres_lock cmd=%0d src=%0d expected cmd=9 src=1", c, s);
      end
      tests_run++;
      if (t_issue - t15 !== 21) begin
         tests_failed++;
         $display("FAIL lres_timing got=%0d expected=21", t_issue - t15);
      end
   endtask

   task automatic test_hold();
      logic [3:0] c;
      logic s;
      int p0;
      bit saw;
      resync();
      push(4'd5);
      serve(1'b1, 0, c, s);
      tests_run++;
      if (c !== 4'd5 || s !== 1'b0) begin
         tests_failed++;
         $display("FAIL hold_first cmd=%0d src=%0d expected cmd=5 src=0", c, s);
      end
      p0 = pop_cnt;
      saw = 0;
      push(4'd5);
      repeat (6) begin
         @(negedge clk);
         if (cmd_valid) saw = 1;
      end
      tests_run++;
      if (saw !== 1'b0 || pop_cnt - p0 !== 1) begin
         tests_failed++;
         $display("FAIL hold_discard saw_valid=%0d pops=%0d expected 0 1", saw, pop_cnt - p0);
      end
      push(4'd4);
      serve(1'b1, 0, c, s);
      tests_run++;
      if (c !== 4'd4) begin
         tests_failed++;
         $display("FAIL hold_drop cmd=%0d expected=4", c);
      end
      push(4'd5);
      serve(1'b1, 0, c, s);
      tests_run++;
      if (c !== 4'd5 || s !== 1'b0) begin
         tests_failed++;
         $display("FAIL hold_again cmd=%0d src=%0d expected cmd=5 src=0", c, s);
      end
   endtask

   task automatic test_stall_pause();
      logic [3:0] c;
      logic s;
      int p0, r0;
      bit seen = 0;
      bit saw = 0;
      resync();
      push(4'd1);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_valid) begin
            seen = 1;
            break;
         end
      end
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL stall_issue cmd_valid=0 expected=1");
      end
      p0 = pop_cnt;
      push(4'd1);
      repeat (10) begin
         @(negedge clk);
         tests_run++;
         if ({cmd_valid, cmd, cmd_src} !== {1'b1, 4'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL stall_hold valid=%0d cmd=%0d src=%0d expected 1 1 0", cmd_valid, cmd, cmd_src);
         end
      end
      tests_run++;
      if (pop_cnt !== p0) begin
         tests_failed++;
         $display("FAIL stall_pop pops=%0d expected=%0d", pop_cnt, p0);
      end
      serve(1'b1, 0, c, s);
      serve(1'b1, 0, c, s);
      tests_run++;
      if (c !== 4'd1 || s !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_next cmd=%0d src=%0d expected cmd=1 src=0", c, s);
      end
      resync();
      r0 = cyc;
      pause = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (cmd_valid || ctrl_pop) saw = 1;
      end
      pause = 1'b0;
      tests_run++;
      if (saw !== 1'b0) begin
         tests_failed++;
         $display("FAIL pause_quiet activity=%0d expected=0", saw);
      end
      serve(1'b1, 0, c, s);
      tests_run++;
      if (c !== 4'd3 || t_issue - r0 !== 151) begin
         tests_failed++;
         $display("FAIL pause_freeze cmd=%0d delay=%0d expected cmd=3 delay=151", c, t_issue - r0);
      end
   endtask

   task automatic test_game_over_reset();
      logic [3:0] c;
      logic s;
      bit seen = 0;
      resync();
      serve(1'b0, 0, c, s);
      game_over = 1'b1;
      @(negedge clk);
      game_over = 1'b0;
      tests_run++;
      if (landed !== 1'b0) begin
         tests_failed++;
         $display("FAIL gameover_unland landed=%0d expected=0", landed);
      end
      push(4'd2);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_valid) begin
            seen = 1;
            break;
         end
      end
      reset_n = 1'b0;
      @(negedge clk);
      tests_run++;
      if (!seen || cmd_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid issued=%0d valid=%0d busy=%0d expected 1 0 0", seen, cmd_valid, busy);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_gravity();
      test_alternate();
      test_lock();
      test_lock_resets();
      test_hold();
      test_stall_pause();
      test_game_over_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
